// File: rtl/shift_pkg.sv
// shift_pkg: op and state encodings shared by the shifter, decoder and ALU control
package shift_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit left/right shift with an explicit fill bit
module shift_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] data_i,
  input  logic         left_i,
  input  logic         fill_i,
  output logic [N-1:0] data_o
);
  always_comb data_o = left_i ? {data_i[N-2:0], fill_i} : {fill_i, data_i[N-1:1]};
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative SLL/SRL/SRA, one bit per clock, with busy/done handshake
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   operand,
  input  logic [SHW-1:0] shamt,
  input  logic           flush,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);
  state_e         state_q;
  logic [SHW-1:0] cnt_q;
  logic [1:0]     op_q;
  logic [N-1:0]   sr_q, sr_d;
  logic           busy_q, done_q;
  // op bit 0 clear means left (SLL and the reserved 10); only SRA replicates the sign
  shift_step #(.N(N)) u_step (
    .data_i(sr_q),
    .left_i(~op_q[0]),
    .fill_i(op_q == OP_SRA && sr_q[N-1]),
    .data_o(sr_d)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else if (start) begin
      sr_q    <= operand;
      cnt_q   <= shamt;
      op_q    <= op;
      state_q <= (shamt == '0) ? DONE : SHIFT;
      busy_q  <= (shamt != '0);
      done_q  <= (shamt == '0);
    end else begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = sr_q;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the execute stage. It performs SLL, SRL and SRA by stepping one shared one-bit shift stage once per clock, up to N−1 times. It raises busy so the hazard unit can stall the pipeline, and pulses done when the result is ready. This replaces a full barrel shifter with a small iterative datapath.

## Interface
- N, default 32: operand and result width.
- SHW, default 5: shift-amount width, equal to clog2(N).

Ports (name, direction, width, meaning):
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset. One clock domain only.
- start, input, 1: request a shift. Sampled only when the block is accepting (IDLE or DONE state).
- op, input, 2: shift type. 00 = SLL, 01 = SRL, 11 = SRA. 10 is reserved and executes as SLL.
- operand, input, N: value to shift. Captured on the accepting edge.
- shamt, input, SHW: shift count, 0..N−1. Captured on the accepting edge.
- flush, input, 1: synchronous abort from the pipeline (branch mispredict or trap).
- busy, output, 1: high while shifting (SHIFT state).
- done, output, 1: one-cycle pulse; result is valid in this cycle.
- result, output, N: shifted value. Holds its value until the next accepted start.

## Operation
- States:
  - IDLE: no operation in progress.
  - SHIFT: one-bit step per cycle.
  - DONE: done pulse cycle.
- IDLE or DONE, with start=1:
  - capture operand into the shift register, shamt into the counter, op into the op register;
  - if shamt=0, go to DONE;
  - otherwise go to SHIFT.
- IDLE or DONE, with start=0: go to (or stay in) IDLE.
- SHIFT, each cycle:
  - shift the register one bit and decrement the counter;
  - if the counter was 1, go to DONE.
- Fill bits:
  - SLL: LSB ← 0.
  - SRL: MSB ← 0.
  - SRA: MSB ← old MSB.
- DONE: done=1 and result equals the shift register.
- start while in SHIFT: ignored, not queued. The requester must hold start until it observes an accepting cycle.
- flush:
  - Has priority over every other event.
  - In any state, the next state is IDLE, with no done and busy low.
  - The shift register (and therefore result) keeps its current value.
  - start in the same cycle as flush is dropped.
- Reset (rst_n=0, at any time, including mid-shift):
  - state IDLE; busy=0, done=0, result=0, counter=0.
  - On release, the block waits for start.
- Width rule: shamt is never interpreted beyond N−1. For N=32, shamt is 5 bits, so no overflow is possible.

## Timing
- Accepting edge E0. For shamt=s≥1:
  - busy is high in the s cycles after E0;
  - the shifts happen on edges E1..Es;
  - done and a valid result appear in the cycle after Es.
- Latency from the start cycle to the done cycle is s+1 cycles.
- For s=0: done appears in the cycle after E0, with result equal to operand.
- Back-to-back operation: start asserted during DONE is accepted on that edge. done lasts exactly one cycle, and busy or DONE follows immediately.
- All outputs are registered state decodes; there are no combinational paths from inputs to outputs.

## Structure
- Package shift_pkg (shared with the decoder and ALU control):
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11;
  - state encoding IDLE, SHIFT, DONE.
- Sub-module shift_step: combinational one-bit shifter.
  - Inputs: data (N bits), dir (left/right), fill bit.
  - Output: the shifted word.
  - Instantiated once and fed by the shift register.
- The top level holds only the FSM, counter, op register and shift register.

## Test plan
- SLL, operand 0x0000_0001, shamt 31: done exactly 32 cycles after the start cycle, result 0x8000_0000; busy high for 31 cycles.
- SRA, operand 0x8000_0000, shamt 4: result 0xF800_0000. Then SRL with the same inputs: result 0x0800_0000. Second start asserted in the DONE cycle: accepted with no idle gap.
- shamt 0, operand 0xDEAD_BEEF, any op: done one cycle later, result 0xDEAD_BEEF, busy never high.
- SRL, operand 0xFFFF_0000, shamt 8, with a second start pulse (shamt 1) during SHIFT: ignored. Single done, result 0x00FF_FF00.
- flush on the 3rd SHIFT cycle of SLL shamt 10: next cycle IDLE with busy=0; no done for at least 20 cycles; a new start then works normally.
- rst_n pulled low mid-shift, asynchronous to clk: busy, done and result are 0 immediately. After release, no spurious done; a fresh SLL of 0x3 by 2 gives 0xC.
